// File: rtl/game_fsm.sv
// Pong match sequencer: serve timing, point hold, scoring and winner.
// All outputs registered; runs on the pixel clock, timed in frame ticks.
`timescale 1ns/1ps
module game_fsm #(
    parameter int WIN_SCORE         = 9,
    parameter int SERVE_DELAY_TICKS = 120,
    parameter int POINT_HOLD_TICKS  = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       timing_tick,
    input  logic       start_btn,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic       ball_en,
    output logic       ball_center,
    output logic       serve_right,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic [1:0] winner,
    output logic [2:0] game_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_t;

    localparam int MAX_T = (SERVE_DELAY_TICKS > POINT_HOLD_TICKS) ?
                           SERVE_DELAY_TICKS : POINT_HOLD_TICKS;
    localparam int CW = $clog2(MAX_T + 1);
    localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_DELAY_TICKS - 1);
    localparam logic [CW-1:0] POINT_LAST = CW'(POINT_HOLD_TICKS - 1);
    localparam logic [3:0]    WIN        = 4'(WIN_SCORE);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      sl_q, sl_d;
    logic [3:0]      sr_q, sr_d;
    logic [1:0]      win_q, win_d;
    logic            serve_q, serve_d;
    logic            ben_q;
    logic            bc_q;
    logic            start_prev;
    logic            start_rise;

    assign start_rise = start_btn & ~start_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sl_q       <= '0;
            sr_q       <= '0;
            win_q      <= 2'b00;
            serve_q    <= 1'b1;
            ben_q      <= 1'b0;
            bc_q       <= 1'b1;
            start_prev <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sl_q       <= sl_d;
            sr_q       <= sr_d;
            win_q      <= win_d;
            serve_q    <= serve_d;
            ben_q      <= (state_d == PLAY);
            bc_q       <= (state_d != PLAY);
            start_prev <= start_btn;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sl_d    = sl_q;
        sr_d    = sr_q;
        win_d   = win_q;
        serve_d = serve_q;
        unique case (state_q)
            IDLE: begin
                if (start_rise)
                    state_d = SERVE;
            end
            SERVE: begin
                if (timing_tick) begin
                    if (cnt_q == SERVE_LAST)
                        state_d = PLAY;
                    else
                        cnt_d = cnt_q + 1'b1;
                end
            end
            PLAY: begin
                if (miss_left && miss_right) begin
                    state_d = POINT;
                end else if (miss_left) begin
                    if (sr_q < WIN)
                        sr_d = sr_q + 4'd1;
                    serve_d = 1'b1;
                    state_d = POINT;
                end else if (miss_right) begin
                    if (sl_q < WIN)
                        sl_d = sl_q + 4'd1;
                    serve_d = 1'b0;
                    state_d = POINT;
                end
            end
            POINT: begin
                if (timing_tick) begin
                    if (cnt_q == POINT_LAST) begin
                        if (sl_q == WIN || sr_q == WIN) begin
                            state_d = OVER;
                            win_d   = (sl_q == WIN) ? 2'b01 : 2'b10;
                        end else begin
                            state_d = SERVE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            OVER: begin
                if (start_rise) begin
                    sl_d    = '0;
                    sr_d    = '0;
                    win_d   = 2'b00;
                    serve_d = 1'b1;
                    state_d = SERVE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Every state entry restarts the frame counter.
        if (state_d != state_q)
            cnt_d = '0;
    end

    assign ball_en     = ben_q;
    assign ball_center = bc_q;
    assign serve_right = serve_q;
    assign score_left  = sl_q;
    assign score_right = sr_q;
    assign winner      = win_q;
    assign game_state  = state_q;

endmodule

// File: tb/tb_game_fsm.sv
// Directed self-checking bench for game_fsm.
// WIN_SCORE=3, SERVE_DELAY_TICKS=4, POINT_HOLD_TICKS=2, tick every 8 clk.
`timescale 1ns/1ps
module tb_game_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       timing_tick;
    logic       start_btn;
    logic       miss_left;
    logic       miss_right;
    logic       ball_en;
    logic       ball_center;
    logic       serve_right;
    logic [3:0] score_left;
    logic [3:0] score_right;
    logic [1:0] winner;
    logic [2:0] game_state;

    int n_pass = 0;
    int n_total = 0;

    game_fsm #(
        .WIN_SCORE(3),
        .SERVE_DELAY_TICKS(4),
        .POINT_HOLD_TICKS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .timing_tick(timing_tick),
        .start_btn(start_btn),
        .miss_left(miss_left),
        .miss_right(miss_right),
        .ball_en(ball_en),
        .ball_center(ball_center),
        .serve_right(serve_right),
        .score_left(score_left),
        .score_right(score_right),
        .winner(winner),
        .game_state(game_state)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic frame();
        repeat (7) cyc();
        timing_tick = 1'b1;
        cyc();
        timing_tick = 1'b0;
    endtask

    task automatic miss(input logic l, input logic r);
        miss_left  = l;
        miss_right = r;
        cyc();
        miss_left  = 1'b0;
        miss_right = 1'b0;
    endtask

    task automatic start_edge();
        start_btn = 1'b0;
        cyc();
        start_btn = 1'b1;
        cyc();
    endtask

    task automatic serve_to_play(input string tag);
        repeat (4) frame();
        chk({tag, "_play"}, 8'(game_state), 8'd2);
    endtask

    task automatic hold_point(input string tag);
        repeat (2) frame();
        chk({tag, "_serve"}, 8'(game_state), 8'd1);
    endtask

    initial begin
        rst         = 1'b1;
        start_btn   = 1'b1;
        timing_tick = 1'b0;
        miss_left   = 1'b0;
        miss_right  = 1'b0;
        repeat (3) cyc();
        chk("rst_state", 8'(game_state), 8'd0);
        chk("rst_sl", 8'(score_left), 8'd0);
        chk("rst_sr", 8'(score_right), 8'd0);
        chk("rst_win", 8'(winner), 8'd0);
        chk("rst_serve", 8'(serve_right), 8'd1);
        chk("rst_ben", 8'(ball_en), 8'd0);
        chk("rst_bc", 8'(ball_center), 8'd1);

        // 1: button held through reset must not start a match
        rst = 1'b0;
        repeat (5) cyc();
        chk("held_idle", 8'(game_state), 8'd0);
        start_edge();
        chk("start_serve", 8'(game_state), 8'd1);

        // 2: ball released one cycle after the 4th tick
        repeat (3) frame();
        chk("serve3_state", 8'(game_state), 8'd1);
        chk("serve3_ben", 8'(ball_en), 8'd0);
        frame();
        chk("serve4_ben", 8'(ball_en), 8'd1);
        chk("serve4_bc", 8'(ball_center), 8'd0);
        chk("serve4_state", 8'(game_state), 8'd2);

        // 3: left miss scores for right
        miss(1'b1, 1'b0);
        chk("ml_sr", 8'(score_right), 8'd1);
        chk("ml_sl", 8'(score_left), 8'd0);
        chk("ml_serve", 8'(serve_right), 8'd1);
        chk("ml_state", 8'(game_state), 8'd3);
        chk("ml_ben", 8'(ball_en), 8'd0);
        chk("ml_bc", 8'(ball_center), 8'd1);
        frame();
        chk("ml_hold1", 8'(game_state), 8'd3);
        frame();
        chk("ml_serve_st", 8'(game_state), 8'd1);
        serve_to_play("t3");

        // 4: simultaneous misses
        miss(1'b1, 1'b1);
        chk("both_state", 8'(game_state), 8'd3);
        chk("both_sl", 8'(score_left), 8'd0);
        chk("both_sr", 8'(score_right), 8'd1);
        chk("both_serve", 8'(serve_right), 8'd1);
        hold_point("t4");
        serve_to_play("t4");

        // 5: left wins 3:1
        miss(1'b0, 1'b1);
        chk("mr1_sl", 8'(score_left), 8'd1);
        chk("mr1_serve", 8'(serve_right), 8'd0);
        hold_point("t5a");
        serve_to_play("t5a");
        miss(1'b0, 1'b1);
        chk("mr2_sl", 8'(score_left), 8'd2);
        hold_point("t5b");
        serve_to_play("t5b");
        miss(1'b0, 1'b1);
        chk("mr3_sl", 8'(score_left), 8'd3);
        chk("mr3_state", 8'(game_state), 8'd3);
        miss(1'b1, 1'b0);
        chk("pt_ignore_sr", 8'(score_right), 8'd1);
        repeat (2) frame();
        chk("over_state", 8'(game_state), 8'd4);
        chk("over_win", 8'(winner), 8'd1);
        chk("over_sl", 8'(score_left), 8'd3);
        chk("over_ben", 8'(ball_en), 8'd0);
        miss(1'b1, 1'b0);
        miss(1'b0, 1'b1);
        frame();
        chk("over_hold_sl", 8'(score_left), 8'd3);
        chk("over_hold_sr", 8'(score_right), 8'd1);
        chk("over_hold_win", 8'(winner), 8'd1);
        chk("over_hold_st", 8'(game_state), 8'd4);
        start_edge();
        chk("restart_sl", 8'(score_left), 8'd0);
        chk("restart_sr", 8'(score_right), 8'd0);
        chk("restart_win", 8'(winner), 8'd0);
        chk("restart_serve", 8'(serve_right), 8'd1);
        chk("restart_state", 8'(game_state), 8'd1);

        // 6: reset in PLAY at 2:1
        serve_to_play("t6a");
        miss(1'b1, 1'b0);
        hold_point("t6a");
        serve_to_play("t6b");
        miss(1'b0, 1'b1);
        hold_point("t6b");
        serve_to_play("t6c");
        miss(1'b0, 1'b1);
        hold_point("t6c");
        serve_to_play("t6d");
        chk("pre_rst_sl", 8'(score_left), 8'd2);
        chk("pre_rst_sr", 8'(score_right), 8'd1);
        chk("pre_rst_serve", 8'(serve_right), 8'd0);
        start_edge();
        chk("play_no_restart", 8'(game_state), 8'd2);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_rst_state", 8'(game_state), 8'd0);
        chk("mid_rst_sl", 8'(score_left), 8'd0);
        chk("mid_rst_sr", 8'(score_right), 8'd0);
        chk("mid_rst_bc", 8'(ball_center), 8'd1);
        chk("mid_rst_ben", 8'(ball_en), 8'd0);
        chk("mid_rst_serve", 8'(serve_right), 8'd1);
        repeat (3) cyc();
        chk("post_rst_idle", 8'(game_state), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
